// File: rtl/ps2_scan_decoder_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDecode
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_CODE_W = 9;
  localparam int unsigned PS2_MAP_W  = 512;

  // PS/2 uses odd parity over data plus parity bit
  function automatic logic ps2_parity_ok(logic [7:0] data, logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Bundle of raw PS/2 lines and decoded key-map outputs.
interface ps2_scan_decoder_if;
  import ps2_pkg::*;

  logic                  ps2_clk;
  logic                  ps2_data;
  logic [PS2_MAP_W-1:0]  key_down;
  logic [PS2_CODE_W-1:0] last_change;
  logic                  key_valid;
  logic                  frame_err;

  // master: keyboard side driving the lines; slave: the decoder
  modport master (
    output ps2_clk, ps2_data,
    input  key_down, last_change, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_down, last_change, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_scan_decoder_clk_filter.sv
// Synchronises raw PS/2 lines, deglitches the clock and emits a falling-edge pulse.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            filt_q, filt_d;
  logic            fall_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Level flips on the FILTER_LEN-th consecutive differing sample
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= filt_q & ~filt_d;
    end
  end

  assign data_o = data_sync_q[1];
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 frame receiver with E0/F0 prefix handling and a 512-bit held-key map.
// Define PS2_PARITY_CHECK_EN to discard frames with even parity.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input logic                clk,
  input logic                rst,
  ps2_scan_decoder_if.slave  bus_io
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic data_s, fall_s;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i      (clk),
    .rst_i      (rst),
    .ps2_clk_i  (bus_io.ps2_clk),
    .ps2_data_i (bus_io.ps2_data),
    .data_o     (data_s),
    .fall_o     (fall_s)
  );

  ps2_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  ext_q, ext_d, brk_q, brk_d;
  logic [PS2_MAP_W-1:0]  key_down_q, key_down_d;
  logic [PS2_CODE_W-1:0] last_q, last_d, code;
  logic                  kv_q, kv_d, fe_q, fe_d;
  logic                  frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = data_s & ps2_parity_ok(shift_q, parity_q);
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign frame_ok      = data_s;
`endif

  assign code = {ext_q, shift_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = '0;
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_down_d = key_down_q;
    last_d     = last_q;
    kv_d       = 1'b0;
    fe_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall_s) begin
          if (!data_s) begin
            state_d   = StRecv;
            bit_cnt_d = 4'd1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (fall_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {data_s, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            parity_d = data_s;
          end else if (frame_ok) begin
            state_d = StDecode;
          end else begin
            state_d = StIdle;
            fe_d    = 1'b1;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
          fe_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDecode: begin
        state_d = StIdle;
        if (shift_q == PS2_PREFIX_EXT) begin
          ext_d = 1'b1;
        end else if (shift_q == PS2_PREFIX_BRK) begin
          brk_d = 1'b1;
        end else begin
          last_d           = code;
          key_down_d[code] = ~brk_q;
          kv_d             = 1'b1;
          ext_d            = 1'b0;
          brk_d            = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fe_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_down_q <= '0;
      last_q     <= '0;
      kv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_down_q <= key_down_d;
      last_q     <= last_d;
      kv_q       <= kv_d;
      fe_q       <= fe_d;
    end
  end

  assign bus_io.key_down    = key_down_q;
  assign bus_io.last_change = last_q;
  assign bus_io.key_valid   = kv_q;
  assign bus_io.frame_err   = fe_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: decode, prefixes, errors, timeout and reset.
module tb_ps2_scan_decoder;
  import ps2_pkg::*;

  localparam int unsigned FilterLen  = 4;
  localparam int unsigned TimeoutCyc = 200;
  // Posedges from driving ps2_clk low until the fall pulse is visible
  localparam int FallLat = 2 + FilterLen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(
    .FILTER_LEN  (FilterLen),
    .TIMEOUT_CYC (TimeoutCyc)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fe_cyc = 0;
  int checks = 0, failures = 0;
  int fall_cyc = 0;
  int kv_ref, fe_ref;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      kv_cnt = kv_cnt + 1;
      kv_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr[0]    = 1'b0;
    fr[8:1]  = b;
    fr[9]    = ~(^b) ^ bad_par;
    fr[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cyc(5);
      bus.ps2_clk = 1'b0;
      fall_cyc    = cyc;
      wait_cyc(10);
      bus.ps2_clk = 1'b1;
      wait_cyc(5);
    end
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [15:0] kd(input int idx);
    return {15'b0, bus.key_down[idx]};
  endfunction

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(10);

    check("rst_map", {15'b0, |bus.key_down}, 16'h0);
    check("rst_last", {7'b0, bus.last_change}, 16'h0);
    check("rst_kv", {15'b0, bus.key_valid}, 16'h0);
    check("rst_fe", {15'b0, bus.frame_err}, 16'h0);

    // Narrow clock glitch with data high must not look like a bad start bit
    bus.ps2_clk = 1'b0;
    wait_cyc(2);
    bus.ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_fe", 16'(fe_cnt), 16'd0);

    send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("make_bit", kd(12'h01C), 16'h1);
    check("make_last", {7'b0, bus.last_change}, 16'h01C);
    check("make_kv_cnt", 16'(kv_cnt), 16'd1);
    check("make_latency", 16'(kv_cyc - fall_cyc), 16'(FallLat + 2));

    send_frame(8'hF0, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("f0_no_kv", 16'(kv_cnt), 16'd1);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("brk_bit", kd(12'h01C), 16'h0);
    check("brk_last", {7'b0, bus.last_change}, 16'h01C);
    check("brk_kv_cnt", 16'(kv_cnt), 16'd2);

    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("ext_make_bit", kd(12'h175), 16'h1);
    check("ext_make_plain", kd(12'h075), 16'h0);
    check("ext_make_last", {7'b0, bus.last_change}, 16'h175);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("ext_brk_bit", kd(12'h175), 16'h0);
    check("ext_brk_plain", kd(12'h075), 16'h0);
    check("ext_kv_cnt", 16'(kv_cnt), 16'd4);

    kv_ref = kv_cnt;
    fe_ref = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    wait_cyc(20);
`ifdef PS2_PARITY_CHECK_EN
    check("par_fe", 16'(fe_cnt - fe_ref), 16'd1);
    check("par_bit", kd(12'h01C), 16'h0);
    check("par_kv", 16'(kv_cnt - kv_ref), 16'd0);
`else
    check("par_fe", 16'(fe_cnt - fe_ref), 16'd0);
    check("par_bit", kd(12'h01C), 16'h1);
    check("par_kv", 16'(kv_cnt - kv_ref), 16'd1);
`endif

    kv_ref = kv_cnt;
    fe_ref = fe_cnt;
    send_frame(8'h23, 1'b0, 1'b1, 11);
    wait_cyc(20);
    check("stop_fe", 16'(fe_cnt - fe_ref), 16'd1);
    check("stop_fe_latency", 16'(fe_cyc - fall_cyc), 16'(FallLat + 1));
    check("stop_kv", 16'(kv_cnt - kv_ref), 16'd0);

    fe_ref = fe_cnt;
    send_frame(8'h23, 1'b0, 1'b0, 5);
    wait_cyc(TimeoutCyc + 50);
    check("tmo_fe", 16'(fe_cnt - fe_ref), 16'd1);
    check("tmo_latency", 16'(fe_cyc - fall_cyc), 16'(FallLat + 1 + TimeoutCyc));
    send_frame(8'h23, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("tmo_next_bit", kd(12'h023), 16'h1);
    check("tmo_next_last", {7'b0, bus.last_change}, 16'h023);

    fe_ref = fe_cnt;
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 1'b0, 4);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    kv_ref = kv_cnt;
    check("mid_rst_fe", 16'(fe_cnt - fe_ref), 16'd0);
    check("mid_rst_map", {15'b0, |bus.key_down}, 16'h0);
    check("mid_rst_last", {7'b0, bus.last_change}, 16'h0);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_cyc(20);
    check("post_rst_plain", kd(12'h075), 16'h1);
    check("post_rst_ext", kd(12'h175), 16'h0);
    check("post_rst_kv", 16'(kv_cnt - kv_ref), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Receives raw PS/2 keyboard frames, validates them, interprets the E0 (extended) and F0 (break) prefixes, and maintains a 512-bit held-key map. It sits directly upstream of the keyboard controller, which consumes `key_down`, `last_change` and `key_valid` to produce the ESC/ENTER/BACKSPACE/SHIFT pulses and the A/D movement levels. The block is receive-only: the host never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, 4: number of consecutive equal samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYC`, 100000: idle cycles allowed inside a frame before it is aborted (1 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Single clock domain; reset is synchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `key_down`  out  512  held-key map; bit index is `{ext, scan_byte}` (indices 0x000–0x1FF).
- `last_change`  out  9  code of the most recent make or break event.
- `key_valid`  out  1  one-cycle pulse; `key_down` and `last_change` already hold the new values in this cycle.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- **Input synchronisation:** both raw lines pass through a 2-FF synchroniser. `ps2_clk` is then filtered: the filtered level changes only after `FILTER_LEN` equal consecutive samples. `fall` is a one-cycle pulse on a 1→0 transition of the filtered clock. Data is sampled on `fall`.
- **Frame FSM:**
  - IDLE → RECV on `fall` when the sampled data is 0 (start bit). If the start bit is 1: pulse `frame_err`, stay in IDLE.
  - RECV: a 4-bit counter runs 1..10. Bits 1–8 shift in LSB-first, bit 9 is parity, bit 10 is stop.
  - On bit 10, go to DECODE if stop = 1 (and parity is odd when parity checking is enabled). Otherwise pulse `frame_err` and go to IDLE.
  - DECODE lasts one cycle, then returns to IDLE.
  - Timeout: a counter clears on every `fall` and runs only in RECV. When it reaches `TIMEOUT_CYC`, pulse `frame_err` and go to IDLE.
- **Decode (DECODE cycle):**
  - byte 0xE0 → set `ext`. No output change.
  - byte 0xF0 → set `brk`. No output change.
  - any other byte → `code = {ext, byte}`, `last_change <= code`, `key_down[code] <= !brk`, `key_valid` pulses, then `ext` and `brk` clear.
- **Repeats and redundancy:** typematic repeats (a make for a key already held) still pulse `key_valid`; `key_down` is unchanged. A break for a key that is not held still pulses `key_valid`, and the bit stays 0.
- **Errors:** any `frame_err` also clears `ext` and `brk`.
- **Reset:**
  - All outputs go to 0 (`key_down` all zeros, `last_change` = 0, both pulses low).
  - FSM returns to IDLE; counters, `ext` and `brk` clear.
  - The filter and synchroniser registers load 1 (idle bus).
  - Reset mid-frame discards the partial frame with no `frame_err`.
  - `rst` overrides every simultaneous event.

## Timing
- Latency: the stop-bit sample (`fall` cycle) is cycle S; DECODE is S+1; `key_valid`, `last_change` and `key_down` are visible at S+2. `key_valid` lasts exactly one cycle.
- `frame_err` is asserted in the cycle after the failing sample or the timeout hit.
- Consecutive `key_valid` pulses are at least one full PS/2 frame apart; no backpressure is needed.
- `ps2_clk` pulses narrower than `FILTER_LEN` cycles are ignored.
- Between frames (e.g. between E0 and F0) there is no timeout; prefix flags persist until consumed or cleared by error/reset.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: frames with even parity are discarded with a `frame_err` pulse.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is shifted in and ignored. `frame_err` then arises only from a bad start bit, a bad stop bit, or a timeout.

## Structure
- Package `ps2_pkg` holds:
  - FSM state enum (IDLE, RECV, DECODE).
  - `PS2_PREFIX_EXT` = 8'hE0, `PS2_PREFIX_BRK` = 8'hF0.
  - `PS2_CODE_W` = 9 and `PS2_MAP_W` = 512.
- One sub-module, `ps2_clk_filter`, covers the 2-FF synchronisers, the `FILTER_LEN` filter and the `fall` pulse. It outputs synchronised data and `fall`.

## Test plan
- Frame 0x1C (parity 0) → `key_down[0x01C]`=1, `last_change`=0x01C, one `key_valid` pulse at S+2.
- F0 then 1C → `key_down[0x01C]`=0, `last_change`=0x01C, exactly one `key_valid` (none for the F0 frame).
- E0 75, then E0 F0 75 → `key_down[0x175]` set, then cleared; `key_down[0x075]` stays 0 throughout.
- 0x1C sent with even parity → with `PS2_PARITY_CHECK_EN`: `frame_err` pulse, map unchanged; without the macro: accepted as in the first scenario.
- Stop bit 0 → `frame_err`. 5 bits then silence → `frame_err` exactly `TIMEOUT_CYC` cycles after the last `fall`; the next good frame 0x23 decodes normally.
- `rst` asserted mid-frame after E0 → no `frame_err`, all outputs 0, and a following 0x75 sets `key_down[0x075]`, not 0x175.
